// File: rtl/systolic_feed_sequencer_pkg.sv
// Shared types and derived constants for the systolic feed sequencer.
// Drain length is read latency + operand skew + array propagation + PE latency.
package systolic_feed_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_ROWS   = 2;
    localparam int DEF_COLS   = 2;
    localparam int DEF_KBITS  = 8;
    localparam int DEF_PE_LAT = 1;

    function automatic int skew_max(input int rows, input int cols);
        return ((rows > cols) ? rows : cols) - 1;
    endfunction

    function automatic int drain_cycles(input int rows, input int cols, input int pe_lat);
        return 1 + skew_max(rows, cols) + (rows + cols - 2) + pe_lat;
    endfunction

    localparam int SKEW_MAX  = skew_max(DEF_ROWS, DEF_COLS);
    localparam int DRAIN_CYC = drain_cycles(DEF_ROWS, DEF_COLS, DEF_PE_LAT);
    localparam int KMAX      = (1 << DEF_KBITS) - 1;

endpackage

// File: rtl/systolic_feed_sequencer_if.sv
// Control, buffer-read and array-feed signals of the sequencer, bundled as one interface.
// The sequencer connects through the slave modport; the tile-buffer/array side uses master.
interface systolic_feed_sequencer_if
    import systolic_feed_sequencer_pkg::*;
#(
    parameter int DBITS = 8,
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int KBITS = 8
);
    // Control: i_START is a level sampled only in IDLE; i_K is captured with it.
    logic                    i_START;
    logic [KBITS-1:0]        i_K;
    logic                    o_BUSY;
    logic                    o_DONE;
    state_t                  o_STATE;

    // Buffer reads: RDATA is valid the cycle after REN, with no backpressure.
    logic [KBITS-1:0]        o_A_RADDR;
    logic                    o_A_REN;
    logic [ROWS*DBITS-1:0]   i_A_RDATA;
    logic [KBITS-1:0]        o_B_RADDR;
    logic                    o_B_REN;
    logic [COLS*DBITS-1:0]   i_B_RDATA;

    // Array feed: per-lane valid qualifies the matching data slice.
    logic [ROWS*DBITS-1:0]   o_ARR_A;
    logic [ROWS-1:0]         o_ARR_A_VALID;
    logic [COLS*DBITS-1:0]   o_ARR_B;
    logic [COLS-1:0]         o_ARR_B_VALID;

    modport slave (
        input  i_START, i_K, i_A_RDATA, i_B_RDATA,
        output o_BUSY, o_DONE, o_STATE,
        output o_A_RADDR, o_A_REN, o_B_RADDR, o_B_REN,
        output o_ARR_A, o_ARR_A_VALID, o_ARR_B, o_ARR_B_VALID
    );

    modport master (
        output i_START, i_K, i_A_RDATA, i_B_RDATA,
        input  o_BUSY, o_DONE, o_STATE,
        input  o_A_RADDR, o_A_REN, o_B_RADDR, o_B_REN,
        input  o_ARR_A, o_ARR_A_VALID, o_ARR_B, o_ARR_B_VALID
    );

endinterface

// File: rtl/skew_delay_line.sv
// DEPTH-stage data+valid register chain used to skew one operand lane.
// DEPTH=0 degenerates to a wire; data is zeroed on entry when invalid.
module skew_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [WIDTH-1:0] i_DATA,
    input  logic             i_VALID,
    output logic [WIDTH-1:0] o_DATA,
    output logic             o_VALID
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = i_CLK ^ i_RST;
        assign o_DATA  = i_DATA;
        assign o_VALID = i_VALID;
    end else begin : g_regs
        logic [WIDTH-1:0] data_q [DEPTH];
        logic [DEPTH-1:0] valid_q;

        always_ff @(posedge i_CLK or posedge i_RST) begin
            if (i_RST) begin
                for (int s = 0; s < DEPTH; s++) begin
                    data_q[s] <= '0;
                end
                valid_q <= '0;
            end else begin
                data_q[0]  <= i_VALID ? i_DATA : '0;
                valid_q[0] <= i_VALID;
                for (int s = 1; s < DEPTH; s++) begin
                    data_q[s]  <= data_q[s-1];
                    valid_q[s] <= valid_q[s-1];
                end
            end
        end

        assign o_DATA  = data_q[DEPTH-1];
        assign o_VALID = valid_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_feed_sequencer.sv
// Reads K A-columns / B-rows for one tile, skews lane r by r cycles into the array,
// then waits out the drain time and pulses o_DONE.
module systolic_feed_sequencer
    import systolic_feed_sequencer_pkg::*;
#(
    parameter int DBITS  = 8,
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int KBITS  = 8,
    parameter int PE_LAT = 1
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    systolic_feed_sequencer_if.slave bus
);

    localparam int DRAIN = drain_cycles(ROWS, COLS, PE_LAT);
    localparam int CW    = $clog2(DRAIN + 1);

    state_t           state_q;
    logic [KBITS-1:0] k_q;
    logic [KBITS-1:0] addr_q;
    logic [CW-1:0]    cnt_q;
    logic             ren_q;
    logic             rdv_q;
    logic             busy_q;
    logic             done_q;

    // rdv_q is REN delayed to line up with RDATA; it is the unskewed lane valid.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            ren_q   <= 1'b0;
            rdv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rdv_q <= ren_q;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_START) begin
                        busy_q <= 1'b1;
                        if (bus.i_K != '0) begin
                            state_q <= ST_FEED;
                            k_q     <= bus.i_K;
                            addr_q  <= '0;
                            ren_q   <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_FEED: begin
                    // Compared against the latched K so K=all-ones never wraps.
                    if (addr_q == k_q - KBITS'(1)) begin
                        state_q <= ST_DRAIN;
                        ren_q   <= 1'b0;
                        addr_q  <= '0;
                        cnt_q   <= '0;
                    end else begin
                        addr_q <= addr_q + KBITS'(1);
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == CW'(DRAIN - 1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    logic [ROWS*DBITS-1:0] a_data_w;
    logic [ROWS-1:0]       a_valid_w;
    logic [COLS*DBITS-1:0] b_data_w;
    logic [COLS-1:0]       b_valid_w;

    for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
        logic [DBITS-1:0] d;
        logic             v;
        skew_delay_line #(.WIDTH(DBITS), .DEPTH(r)) u_skew (
            .i_CLK   (i_CLK),
            .i_RST   (i_RST),
            .i_DATA  (bus.i_A_RDATA[r*DBITS +: DBITS]),
            .i_VALID (rdv_q),
            .o_DATA  (d),
            .o_VALID (v)
        );
        assign a_data_w[r*DBITS +: DBITS] = v ? d : '0;
        assign a_valid_w[r]               = v;
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_lane
        logic [DBITS-1:0] d;
        logic             v;
        skew_delay_line #(.WIDTH(DBITS), .DEPTH(c)) u_skew (
            .i_CLK   (i_CLK),
            .i_RST   (i_RST),
            .i_DATA  (bus.i_B_RDATA[c*DBITS +: DBITS]),
            .i_VALID (rdv_q),
            .o_DATA  (d),
            .o_VALID (v)
        );
        assign b_data_w[c*DBITS +: DBITS] = v ? d : '0;
        assign b_valid_w[c]               = v;
    end

    assign bus.o_STATE       = state_q;
    assign bus.o_BUSY        = busy_q;
    assign bus.o_DONE        = done_q;
    assign bus.o_A_REN       = ren_q;
    assign bus.o_B_REN       = ren_q;
    assign bus.o_A_RADDR     = addr_q;
    assign bus.o_B_RADDR     = addr_q;
    assign bus.o_ARR_A       = a_data_w;
    assign bus.o_ARR_A_VALID = a_valid_w;
    assign bus.o_ARR_B       = b_data_w;
    assign bus.o_ARR_B_VALID = b_valid_w;

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Bench for systolic_feed_sequencer: 1-cycle tile buffers, a 2x2 output-stationary
// array model fed by the DUT, and cycle-exact checks of reads, skew, valids and done.
module tb_systolic_feed_sequencer;

    logic clk;
    logic rst;
    logic acc_clr;
    int   checks;
    int   failures;

    logic [15:0] a_mem [256];
    logic [15:0] b_mem [256];

    systolic_feed_sequencer_if #(.DBITS(8), .ROWS(2), .COLS(2), .KBITS(8)) bus ();

    systolic_feed_sequencer #(
        .DBITS(8), .ROWS(2), .COLS(2), .KBITS(8), .PE_LAT(1)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tile buffers with one cycle of read latency
    always @(posedge clk) begin
        if (bus.o_A_REN) bus.i_A_RDATA <= a_mem[bus.o_A_RADDR];
        if (bus.o_B_REN) bus.i_B_RDATA <= b_mem[bus.o_B_RADDR];
    end

    // 2x2 array model: A flows right, B flows down, PE accumulates when both valid
    int         acc    [2][2];
    logic [7:0] a_pipe [2][2];
    logic       a_vp   [2][2];
    logic [7:0] b_pipe [2][2];
    logic       b_vp   [2][2];
    logic [7:0] m_a, m_b;
    logic       m_av, m_bv;

    always @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                if (c == 0) begin
                    m_a  = bus.o_ARR_A[r*8 +: 8];
                    m_av = bus.o_ARR_A_VALID[r];
                end else begin
                    m_a  = a_pipe[r][c-1];
                    m_av = a_vp[r][c-1];
                end
                if (r == 0) begin
                    m_b  = bus.o_ARR_B[c*8 +: 8];
                    m_bv = bus.o_ARR_B_VALID[c];
                end else begin
                    m_b  = b_pipe[r-1][c];
                    m_bv = b_vp[r-1][c];
                end
                if (acc_clr) begin
                    acc[r][c]  <= 0;
                    a_vp[r][c] <= 1'b0;
                    b_vp[r][c] <= 1'b0;
                end else begin
                    if (m_av && m_bv) acc[r][c] <= acc[r][c] + int'(m_a) * int'(m_b);
                    a_pipe[r][c] <= m_a;
                    a_vp[r][c]   <= m_av;
                    b_pipe[r][c] <= m_b;
                    b_vp[r][c]   <= m_bv;
                end
            end
        end
    end

    function automatic int golden(input int k, input int r, input int c);
        int s;
        logic [15:0] aw, bw;
        s = 0;
        for (int i = 0; i < k; i++) begin
            aw = a_mem[i];
            bw = b_mem[i];
            s += int'(aw[r*8 +: 8]) * int'(bw[c*8 +: 8]);
        end
        return s;
    endfunction

    // mode 0: scrambled small values; mode 1: a_r=2+k+r, b_c=4+2k+c
    task automatic load_buffers(input int mode);
        for (int k = 0; k < 256; k++) begin
            if (mode == 0) begin
                a_mem[k] = {8'((k * 3 + 1) % 11), 8'((k + 5) % 7)};
                b_mem[k] = {8'((k * 5 + 2) % 13), 8'((k * 7 + 3) % 9)};
            end else begin
                a_mem[k] = {8'(3 + k), 8'(2 + k)};
                b_mem[k] = {8'(5 + 2 * k), 8'(4 + 2 * k)};
            end
        end
    endtask

    // Start presented in cycle 0; drain is 5 cycles for 2x2/PE_LAT=1, so DONE is cycle K+6.
    task automatic run_tile(input int k, input bit poke);
        int last, ren_cnt, i0, i1;
        logic v0, v1, e_ren;
        logic [15:0] e_a, e_b, aw0, aw1, bw0, bw1;
        last    = k + 6;
        ren_cnt = 0;
        @(negedge clk);
        bus.i_START = 1'b1;
        bus.i_K     = 8'(k);
        acc_clr     = 1'b1;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            acc_clr     = 1'b0;
            bus.i_START = poke && (n == 2 || n == k + 3);
            bus.i_K     = 8'd7;
            e_ren = (n <= k);
            v0    = (n >= 2 && n <= k + 1);
            v1    = (n >= 3 && n <= k + 2);
            i0    = v0 ? n - 2 : 0;
            i1    = v1 ? n - 3 : 0;
            aw0 = a_mem[i0]; aw1 = a_mem[i1]; bw0 = b_mem[i0]; bw1 = b_mem[i1];
            e_a = {(v1 ? aw1[15:8] : 8'h00), (v0 ? aw0[7:0] : 8'h00)};
            e_b = {(v1 ? bw1[15:8] : 8'h00), (v0 ? bw0[7:0] : 8'h00)};
            if (bus.o_A_REN) ren_cnt++;

            checks++;
            if (bus.o_A_REN !== e_ren || bus.o_B_REN !== e_ren) begin
                failures++;
                $display("FAIL ren k=%0d cyc=%0d got a=%0b b=%0b exp %0b", k, n, bus.o_A_REN, bus.o_B_REN, e_ren);
            end
            if (e_ren) begin
                checks++;
                if (bus.o_A_RADDR !== 8'(n - 1) || bus.o_B_RADDR !== 8'(n - 1)) begin
                    failures++;
                    $display("FAIL raddr k=%0d cyc=%0d got a=%0d b=%0d exp %0d", k, n, bus.o_A_RADDR, bus.o_B_RADDR, n - 1);
                end
            end
            checks++;
            if (bus.o_ARR_A_VALID !== {v1, v0} || bus.o_ARR_B_VALID !== {v1, v0}) begin
                failures++;
                $display("FAIL lane_valid k=%0d cyc=%0d got a=%b b=%b exp %b", k, n, bus.o_ARR_A_VALID, bus.o_ARR_B_VALID, {v1, v0});
            end
            checks++;
            if (bus.o_ARR_A !== e_a || bus.o_ARR_B !== e_b) begin
                failures++;
                $display("FAIL lane_data k=%0d cyc=%0d got a=%h b=%h exp a=%h b=%h", k, n, bus.o_ARR_A, bus.o_ARR_B, e_a, e_b);
            end
            checks++;
            if (bus.o_BUSY !== 1'b1 || bus.o_DONE !== (n == last)) begin
                failures++;
                $display("FAIL busy_done k=%0d cyc=%0d got busy=%0b done=%0b exp busy=1 done=%0b", k, n, bus.o_BUSY, bus.o_DONE, n == last);
            end
        end
        checks++;
        if (ren_cnt != k) begin
            failures++;
            $display("FAIL read_count k=%0d got %0d exp %0d", k, ren_cnt, k);
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (acc[r][c] != golden(k, r, c)) begin
                    failures++;
                    $display("FAIL matmul k=%0d C[%0d][%0d] got %0d exp %0d", k, r, c, acc[r][c], golden(k, r, c));
                end
            end
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            checks++;
            if (bus.o_BUSY !== 1'b0 || bus.o_DONE !== 1'b0 || bus.o_A_REN !== 1'b0 ||
                bus.o_ARR_A_VALID !== 2'b00 || bus.o_ARR_B_VALID !== 2'b00) begin
                failures++;
                $display("FAIL %s idle cyc=%0d got busy=%0b done=%0b ren=%0b va=%b vb=%b exp all 0",
                         tag, n, bus.o_BUSY, bus.o_DONE, bus.o_A_REN, bus.o_ARR_A_VALID, bus.o_ARR_B_VALID);
            end
        end
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (n == 3) rst = 1'b0;
            outs = {bus.o_BUSY, bus.o_DONE, bus.o_A_REN, bus.o_B_REN, bus.o_A_RADDR, bus.o_B_RADDR,
                    bus.o_ARR_A, bus.o_ARR_A_VALID, bus.o_ARR_B, bus.o_ARR_B_VALID, 6'd0};
            checks++;
            if (outs !== 64'd0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d rst=%0b got %h exp 0", n, rst, outs);
            end
        end
    endtask

    task automatic test_basic();
        load_buffers(0);
        run_tile(3, 1'b0);
        check_idle("basic_after", 4);
    endtask

    task automatic test_k_zero();
        @(negedge clk);
        bus.i_START = 1'b1;
        bus.i_K     = 8'd0;
        @(negedge clk);
        bus.i_START = 1'b0;
        checks++;
        if (bus.o_DONE !== 1'b1 || bus.o_BUSY !== 1'b1 || bus.o_A_REN !== 1'b0 || bus.o_B_REN !== 1'b0 ||
            bus.o_ARR_A_VALID !== 2'b00 || bus.o_ARR_B_VALID !== 2'b00) begin
            failures++;
            $display("FAIL k_zero got done=%0b busy=%0b ren=%0b%0b va=%b vb=%b exp done=1 busy=1 rest 0",
                     bus.o_DONE, bus.o_BUSY, bus.o_A_REN, bus.o_B_REN, bus.o_ARR_A_VALID, bus.o_ARR_B_VALID);
        end
        check_idle("k_zero_after", 3);
    endtask

    task automatic test_start_ignored();
        load_buffers(0);
        run_tile(3, 1'b1);
        check_idle("ignored_after", 6);
    endtask

    task automatic test_reset_mid();
        load_buffers(0);
        @(negedge clk);
        bus.i_START = 1'b1;
        bus.i_K     = 8'd5;
        @(negedge clk);
        bus.i_START = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_A_REN !== 1'b1 || bus.o_A_RADDR !== 8'd1 || bus.o_ARR_A_VALID !== 2'b01) begin
            failures++;
            $display("FAIL pre_reset got ren=%0b addr=%0d va=%b exp ren=1 addr=1 va=01",
                     bus.o_A_REN, bus.o_A_RADDR, bus.o_ARR_A_VALID);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.o_ARR_A_VALID !== 2'b00 || bus.o_ARR_B_VALID !== 2'b00 || bus.o_ARR_A !== 16'h0 ||
            bus.o_A_REN !== 1'b0 || bus.o_BUSY !== 1'b0 || bus.o_DONE !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got va=%b vb=%b a=%h ren=%0b busy=%0b done=%0b exp all 0",
                     bus.o_ARR_A_VALID, bus.o_ARR_B_VALID, bus.o_ARR_A, bus.o_A_REN, bus.o_BUSY, bus.o_DONE);
        end
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_mid_after", 8);
        run_tile(2, 1'b0);
    endtask

    task automatic test_back_to_back();
        load_buffers(1);
        run_tile(4, 1'b0);
        run_tile(1, 1'b0);
        checks++;
        if (acc[0][0] != 8 || acc[0][1] != 10 || acc[1][0] != 12 || acc[1][1] != 15) begin
            failures++;
            $display("FAIL b2b_k1_result got %0d %0d %0d %0d exp 8 10 12 15",
                     acc[0][0], acc[0][1], acc[1][0], acc[1][1]);
        end
        check_idle("b2b_after", 3);
    endtask

    task automatic test_kmax();
        load_buffers(0);
        run_tile(255, 1'b0);
        check_idle("kmax_after", 3);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        acc_clr     = 1'b0;
        bus.i_START = 1'b0;
        bus.i_K     = 8'd0;
        test_reset();
        test_basic();
        test_k_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_kmax();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
